// File: rtl/sb_regfile_pkg.sv
// rtl/sb_regfile_pkg.sv - shared defaults and sizing helper for the scoreboarded register file
package sb_regfile_pkg;

  localparam int DEF_NREG = 32;
  localparam int DEF_DW   = 32;
  localparam int DEF_TW   = 3;

  function automatic int sb_clog2(input int n);
    int r;
    for (r = 0; (1 << r) < n; r++) begin
    end
    return r;
  endfunction

endpackage

// File: rtl/sb_regfile_wb_select.sv
// rtl/sb_regfile_wb_select.sv - sb_wb_select: tag-checked priority pick of the write ports for one address
module sb_wb_select #(
  parameter int NWB = 2,
  parameter int AW  = 5,
  parameter int DW  = 32,
  parameter int TW  = 3
) (
  input  logic [AW-1:0]     addr_i,
  input  logic [TW-1:0]     tag_i,
  input  logic [NWB-1:0]    wb_en_i,
  input  logic [NWB*AW-1:0] wb_addr_i,
  input  logic [NWB*TW-1:0] wb_tag_i,
  input  logic [NWB*DW-1:0] wb_data_i,
  output logic              hit_o,
  output logic [DW-1:0]     data_o
);

  // Scan from the oldest port down so the youngest (port 0) overrides last.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    for (int j = NWB - 1; j >= 0; j--) begin
      if (wb_en_i[j] && (addr_i != '0) &&
          (wb_addr_i[j*AW +: AW] == addr_i) &&
          (wb_tag_i[j*TW +: TW] == tag_i)) begin
        hit_o  = 1'b1;
        data_o = wb_data_i[j*DW +: DW];
      end
    end
  end

endmodule

// File: rtl/sb_regfile.sv
// rtl/sb_regfile.sv - register file with per-register valid bit and issue tag for hazard stalls
module sb_regfile
  import sb_regfile_pkg::*;
#(
  parameter int NREG   = DEF_NREG,
  parameter int DW     = DEF_DW,
  parameter int NRD    = 2,
  parameter int NWB    = 2,
  parameter int TW     = DEF_TW,
  parameter int BYPASS = 1,
  localparam int AW    = sb_clog2(NREG)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NRD*AW-1:0] raddr,
  output logic [NRD*DW-1:0] rdata,
  output logic [NRD-1:0]    rvalid,
  input  logic              id_issue,
  input  logic [AW-1:0]     id_dest,
  output logic [TW-1:0]     id_tag,
  input  logic              flush,
  input  logic [NWB-1:0]    wb_en,
  input  logic [NWB*AW-1:0] wb_addr,
  input  logic [NWB*TW-1:0] wb_tag,
  input  logic [NWB*DW-1:0] wb_data
);

  logic [DW-1:0] data_q  [NREG];
  logic [DW-1:0] data_d  [NREG];
  logic [TW-1:0] tag_q   [NREG];
  logic [TW-1:0] tag_d   [NREG];
  logic [NREG-1:0] valid_q, valid_d;
  logic [TW-1:0] cnt_q, cnt_d;

  logic [NREG-1:0] upd_hit;
  logic [DW-1:0]   upd_data [NREG];

  // Register 0 never hits (address 0 excluded), so it stays 0 / valid forever.
  for (genvar r = 0; r < NREG; r++) begin : g_upd
    sb_wb_select #(.NWB(NWB), .AW(AW), .DW(DW), .TW(TW)) u_sel (
      .addr_i    (AW'(r)),
      .tag_i     (tag_q[r]),
      .wb_en_i   (wb_en),
      .wb_addr_i (wb_addr),
      .wb_tag_i  (wb_tag),
      .wb_data_i (wb_data),
      .hit_o     (upd_hit[r]),
      .data_o    (upd_data[r])
    );
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] ra;
    logic          byp_hit;
    logic [DW-1:0] byp_data;
    assign ra = raddr[k*AW +: AW];
    sb_wb_select #(.NWB(NWB), .AW(AW), .DW(DW), .TW(TW)) u_byp (
      .addr_i    (ra),
      .tag_i     (tag_q[ra]),
      .wb_en_i   (wb_en),
      .wb_addr_i (wb_addr),
      .wb_tag_i  (wb_tag),
      .wb_data_i (wb_data),
      .hit_o     (byp_hit),
      .data_o    (byp_data)
    );
    assign rdata[k*DW +: DW] = ((BYPASS != 0) && byp_hit && !flush) ? byp_data : data_q[ra];
    assign rvalid[k]         = ((BYPASS != 0) && byp_hit && !flush) ? 1'b1 : valid_q[ra];
  end

  assign id_tag = cnt_q;

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      data_d[r] = data_q[r];
      tag_d[r]  = tag_q[r];
    end
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (flush) begin
      valid_d = '1;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (upd_hit[r]) begin
          data_d[r]  = upd_data[r];
          valid_d[r] = 1'b1;
        end
      end
      // Issue applied after the writes so it wins for valid and tag.
      if (id_issue && (id_dest != '0)) begin
        valid_d[id_dest] = 1'b0;
        tag_d[id_dest]   = cnt_q;
        cnt_d            = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int r = 0; r < NREG; r++) begin
        data_q[r] <= '0;
        tag_q[r]  <= '0;
      end
      valid_q <= '1;
      cnt_q   <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        data_q[r] <= data_d[r];
        tag_q[r]  <= tag_d[r];
      end
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_sb_regfile.sv
// tb/tb_sb_regfile.sv - directed self-checking bench for sb_regfile
module tb_sb_regfile;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int TW = 3;

  logic            clk = 1'b0;
  logic            resetn;
  logic [2*AW-1:0] raddr;
  logic [2*DW-1:0] rdata;
  logic [1:0]      rvalid;
  logic            id_issue;
  logic [AW-1:0]   id_dest;
  logic [TW-1:0]   id_tag;
  logic            flush;
  logic [1:0]      wb_en;
  logic [2*AW-1:0] wb_addr;
  logic [2*TW-1:0] wb_tag;
  logic [2*DW-1:0] wb_data;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sb_regfile dut (
    .clk(clk), .resetn(resetn), .raddr(raddr), .rdata(rdata), .rvalid(rvalid),
    .id_issue(id_issue), .id_dest(id_dest), .id_tag(id_tag), .flush(flush),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_tag(wb_tag), .wb_data(wb_data)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_issue = 1'b0; id_dest = '0; flush = 1'b0;
    wb_en = '0; wb_addr = '0; wb_tag = '0; wb_data = '0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; idle(); raddr = {5'd0, 5'd5};
    step(); step();
    resetn = 1'b1; #1;
    n_vec++; if (rdata !== 64'd0) begin n_err++; $display("FAIL reset_rdata got %h want 0", rdata); end
    n_vec++; if (rvalid !== 2'b11) begin n_err++; $display("FAIL reset_rvalid got %b want 11", rvalid); end
    n_vec++; if (id_tag !== 3'd0) begin n_err++; $display("FAIL reset_id_tag got %0d want 0", id_tag); end
  endtask

  task automatic test_issue_write();
    id_issue = 1'b1; id_dest = 5'd3; #1;
    n_vec++; if (id_tag !== 3'd0) begin n_err++; $display("FAIL iw_tag got %0d want 0", id_tag); end
    step(); idle(); raddr = {5'd0, 5'd3}; #1;
    n_vec++; if (rvalid[0] !== 1'b0) begin n_err++; $display("FAIL iw_pending got %b want 0", rvalid[0]); end
    wb_en = 2'b10; wb_addr = {5'd3, 5'd0}; wb_tag = {3'd0, 3'd0}; wb_data = {32'hDEADBEEF, 32'd0}; #1;
    n_vec++; if (rdata[31:0] !== 32'hDEADBEEF || rvalid[0] !== 1'b1) begin
      n_err++; $display("FAIL iw_bypass got %h/%b want deadbeef/1", rdata[31:0], rvalid[0]); end
    step(); idle(); #1;
    n_vec++; if (rdata[31:0] !== 32'hDEADBEEF || rvalid[0] !== 1'b1) begin
      n_err++; $display("FAIL iw_array got %h/%b want deadbeef/1", rdata[31:0], rvalid[0]); end
  endtask

  task automatic test_stale();
    raddr = {5'd0, 5'd7};
    id_issue = 1'b1; id_dest = 5'd7; #1;
    n_vec++; if (id_tag !== 3'd1) begin n_err++; $display("FAIL stale_tag1 got %0d want 1", id_tag); end
    step(); #1;
    n_vec++; if (id_tag !== 3'd2) begin n_err++; $display("FAIL stale_tag2 got %0d want 2", id_tag); end
    step(); idle();
    wb_en = 2'b01; wb_addr = {5'd0, 5'd7}; wb_tag = {3'd0, 3'd1}; wb_data = {32'd0, 32'h11}; #1;
    n_vec++; if (rvalid[0] !== 1'b0 || rdata[31:0] !== 32'd0) begin
      n_err++; $display("FAIL stale_bypass got %h/%b want 0/0", rdata[31:0], rvalid[0]); end
    step(); idle(); #1;
    n_vec++; if (rvalid[0] !== 1'b0 || rdata[31:0] !== 32'd0) begin
      n_err++; $display("FAIL stale_ignored got %h/%b want 0/0", rdata[31:0], rvalid[0]); end
    wb_en = 2'b01; wb_addr = {5'd0, 5'd7}; wb_tag = {3'd0, 3'd2}; wb_data = {32'd0, 32'h22};
    step(); idle(); #1;
    n_vec++; if (rvalid[0] !== 1'b1 || rdata[31:0] !== 32'h22) begin
      n_err++; $display("FAIL stale_current got %h/%b want 22/1", rdata[31:0], rvalid[0]); end
  endtask

  task automatic test_priority();
    raddr = {5'd4, 5'd4};
    wb_en = 2'b11; wb_addr = {5'd4, 5'd4}; wb_tag = {3'd0, 3'd0}; wb_data = {32'hB, 32'hA}; #1;
    n_vec++; if (rdata !== {32'hA, 32'hA}) begin n_err++; $display("FAIL prio_bypass got %h want a/a", rdata); end
    step(); idle(); #1;
    n_vec++; if (rdata[31:0] !== 32'hA || rvalid !== 2'b11) begin
      n_err++; $display("FAIL prio_array got %h/%b want a/11", rdata[31:0], rvalid); end
  endtask

  task automatic test_issue_and_write();
    raddr = {5'd0, 5'd9};
    id_issue = 1'b1; id_dest = 5'd9;
    wb_en = 2'b01; wb_addr = {5'd0, 5'd9}; wb_tag = {3'd0, 3'd0}; wb_data = {32'd0, 32'h55}; #1;
    n_vec++; if (id_tag !== 3'd3) begin n_err++; $display("FAIL iaw_tag got %0d want 3", id_tag); end
    n_vec++; if (rdata[31:0] !== 32'h55 || rvalid[0] !== 1'b1) begin
      n_err++; $display("FAIL iaw_bypass got %h/%b want 55/1", rdata[31:0], rvalid[0]); end
    step(); idle(); #1;
    n_vec++; if (rdata[31:0] !== 32'h55 || rvalid[0] !== 1'b0) begin
      n_err++; $display("FAIL iaw_array got %h/%b want 55/0", rdata[31:0], rvalid[0]); end
    n_vec++; if (id_tag !== 3'd4) begin n_err++; $display("FAIL iaw_cnt got %0d want 4", id_tag); end
  endtask

  task automatic test_flush();
    raddr = {5'd6, 5'd2};
    id_issue = 1'b1; id_dest = 5'd2; step();
    id_dest = 5'd6; step(); idle(); #1;
    n_vec++; if (rvalid !== 2'b00) begin n_err++; $display("FAIL flush_pending got %b want 00", rvalid); end
    flush = 1'b1; id_issue = 1'b1; id_dest = 5'd5;
    wb_en = 2'b01; wb_addr = {5'd0, 5'd2}; wb_tag = {3'd0, 3'd4}; wb_data = {32'd0, 32'h77}; #1;
    n_vec++; if (rdata[31:0] !== 32'd0 || rvalid[0] !== 1'b0) begin
      n_err++; $display("FAIL flush_nobypass got %h/%b want 0/0", rdata[31:0], rvalid[0]); end
    step(); idle(); #1;
    n_vec++; if (rvalid !== 2'b11 || rdata[31:0] !== 32'd0) begin
      n_err++; $display("FAIL flush_after got %h/%b want 0/11", rdata[31:0], rvalid); end
    raddr = {5'd5, 5'd2}; #1;
    n_vec++; if (rvalid[1] !== 1'b1) begin n_err++; $display("FAIL flush_issue_ignored got %b want 1", rvalid[1]); end
    n_vec++; if (id_tag !== 3'd6) begin n_err++; $display("FAIL flush_cnt got %0d want 6", id_tag); end
  endtask

  task automatic test_r0();
    raddr = {5'd0, 5'd0};
    id_issue = 1'b1; id_dest = 5'd0;
    wb_en = 2'b01; wb_addr = '0; wb_tag = '0; wb_data = {32'd0, 32'h99}; #1;
    n_vec++; if (rdata !== 64'd0 || rvalid !== 2'b11) begin
      n_err++; $display("FAIL r0_same got %h/%b want 0/11", rdata, rvalid); end
    step(); idle(); #1;
    n_vec++; if (rdata !== 64'd0 || rvalid !== 2'b11) begin
      n_err++; $display("FAIL r0_after got %h/%b want 0/11", rdata, rvalid); end
    n_vec++; if (id_tag !== 3'd6) begin n_err++; $display("FAIL r0_cnt got %0d want 6", id_tag); end
  endtask

  task automatic test_wrap();
    resetn = 1'b0; step(); resetn = 1'b1; #1;
    raddr = {5'd3, 5'd1};
    n_vec++; if (rdata !== 64'd0 || rvalid !== 2'b11 || id_tag !== 3'd0) begin
      n_err++; $display("FAIL midreset got %h/%b/%0d want 0/11/0", rdata, rvalid, id_tag); end
    for (int i = 0; i < 9; i++) begin
      id_issue = 1'b1; id_dest = 5'd1; #1;
      n_vec++; if (id_tag !== 3'(i % 8)) begin
        n_err++; $display("FAIL wrap_issue%0d got %0d want %0d", i, id_tag, i % 8); end
      step();
    end
    idle(); #1;
    n_vec++; if (id_tag !== 3'd1) begin n_err++; $display("FAIL wrap_final got %0d want 1", id_tag); end
    n_vec++; if (rvalid !== 2'b10) begin n_err++; $display("FAIL wrap_valid got %b want 10", rvalid); end
  endtask

  initial begin
    test_reset();
    test_issue_write();
    test_stale();
    test_priority();
    test_issue_and_write();
    test_flush();
    test_r0();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
